button_command_scheduler: RTL and testbench

Front-end controller that shares one command channel among several raw pushbuttons. Per button it synchronizes, debounces and single-pulses the active-low input, then arbitrates the pulses with fixed priority into a small command FIFO. The FIFO is drained by a downstream datapath over a valid/ready handshake. It sits between board switches and any control FSM that consumes one button event per command.

---
 rtl/button_command_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_button_command_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_command_scheduler.sv
// -----------------------------------------------------------------------------
// button_command_scheduler
//
// Shares one command channel among N_BTN raw active-low pushbuttons. Each
// button is synchronized (2 flops), debounced by a small FSM that emits a
// single-cycle pulse per physical press, and latched into a pending flag.
// A fixed-priority arbiter (lowest index wins) moves one pending flag per
// cycle into a command FIFO that is drained over a valid/ready handshake.
//
// Ports
//   Clock          : single clock, rising edge
//   Resetn         : asynchronous active-low reset
//   btn_n          : raw asynchronous buttons, 0 = pressed
//   cmd_ready      : downstream accepts the head command
//   cmd_valid      : FIFO non-empty
//   cmd_id         : button index at the FIFO head
//   pending_count  : FIFO occupancy, 0..FIFO_DEPTH
//   overflow       : sticky, set when a press event is lost
//   busy           : any pending flag set or FIFO non-empty
// -----------------------------------------------------------------------------
module button_command_scheduler #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        Clock,
  input  logic                        Resetn,
  input  logic [N_BTN-1:0]            btn_n,
  input  logic                        cmd_ready,
  output logic                        cmd_valid,
  output logic [$clog2(N_BTN)-1:0]    cmd_id,
  output logic [$clog2(FIFO_DEPTH):0] pending_count,
  output logic                        overflow,
  output logic                        busy
);

  localparam int IDW = $clog2(N_BTN);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);

  // Counter value on the sample *before* the last one of a stable run.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LOW,
    ST_PRESS,
    ST_HELD,
    ST_CNT_HIGH
  } btn_state_e;

  // Synchronizer
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] s_q;

  // Debounce FSMs
  btn_state_e       state_q [N_BTN];
  btn_state_e       state_d [N_BTN];
  logic [CW-1:0]    cnt_q   [N_BTN];
  logic [CW-1:0]    cnt_d   [N_BTN];
  logic [N_BTN-1:0] pulse;

  // Pending flags / arbiter
  logic [N_BTN-1:0] pending_q;
  logic [N_BTN-1:0] pending_d;
  logic [N_BTN-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic             overflow_q;
  logic             overflow_d;

  // FIFO
  logic [IDW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [PW:0]      count_q;
  logic [PW:0]      count_d;
  logic [IDW-1:0]   cmd_id_q;
  logic [IDW-1:0]   cmd_id_d;
  logic             pop;
  logic             push;
  logic             push_allowed;

  // ---- Synchronizer stage: released (1) out of reset so a button held
  // through reset is seen as a fresh falling edge afterwards.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= '1;
      s_q     <= '1;
    end else begin
      sync1_q <= btn_n;
      s_q     <= sync1_q;
    end
  end

  // ---- Debounce FSM stage
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse[i]   = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (!s_q[i]) begin
            state_d[i] = ST_CNT_LOW;
            cnt_d[i]   = CW'(1);
          end
        end
        ST_CNT_LOW: begin
          if (s_q[i]) begin
            state_d[i] = ST_IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_PRESS;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        ST_PRESS: begin
          pulse[i]   = 1'b1;
          state_d[i] = ST_HELD;
        end
        ST_HELD: begin
          if (s_q[i]) begin
            state_d[i] = ST_CNT_HIGH;
            cnt_d[i]   = CW'(1);
          end
        end
        ST_CNT_HIGH: begin
          if (!s_q[i]) begin
            state_d[i] = ST_HELD;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // ---- Arbitration / pending stage
  assign pop          = cmd_valid & cmd_ready;
  assign push_allowed = (count_q != CNT_FULL) | pop;

  always_comb begin
    grant_idx = '0;
    // Descending scan so the lowest set index is the one left standing.
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) grant_idx = IDW'(i);
    end
    grant = '0;
    if (push_allowed && (|pending_q)) grant[grant_idx] = 1'b1;
  end

  assign push       = |grant;
  assign pending_d  = (pending_q & ~grant) | pulse;
  assign overflow_d = overflow_q | (|(pulse & pending_q & ~grant));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // ---- FIFO stage
  assign rd_ptr_nxt = rd_ptr_q + PW'(1);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // The head is kept in its own register so it reads 0 after reset and
  // holds its last value while empty. The entry behind the head is always
  // already stored when a pop happens with more than one entry.
  always_comb begin
    cmd_id_d = cmd_id_q;
    if (pop) begin
      if (count_q > (PW + 1)'(1)) begin
        cmd_id_d = mem_q[rd_ptr_nxt];
      end else if (push) begin
        cmd_id_d = grant_idx;
      end
    end else if (push && (count_q == '0)) begin
      cmd_id_d = grant_idx;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cmd_id_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_d;
      cmd_id_q <= cmd_id_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= grant_idx;
  end

  // ---- Outputs
  assign cmd_valid     = (count_q != '0);
  assign cmd_id        = cmd_id_q;
  assign pending_count = count_q;
  assign overflow      = overflow_q;
  assign busy          = (|pending_q) | (count_q != '0);

endmodule

// File: tb/tb_button_command_scheduler.sv
module tb_button_command_scheduler;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [3:0] btn_n;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [2:0] pending_count;
  logic       overflow;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  button_command_scheduler #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .btn_n        (btn_n),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .cmd_id       (cmd_id),
    .pending_count(pending_count),
    .overflow     (overflow),
    .busy         (busy)
  );

  // ---------------- reference model (run-length debounce + queue FIFO)
  bit m_sync1 [N];
  bit m_s     [N];
  int m_run   [N];
  bit m_armed [N];
  bit m_pulse [N];
  bit m_pend  [N];
  bit m_ovf;
  int m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sync1[i] = 1'b1;
      m_s[i]     = 1'b1;
      m_run[i]   = 0;
      m_armed[i] = 1'b1;
      m_pulse[i] = 1'b0;
      m_pend[i]  = 1'b0;
    end
    m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit pop;
    bit can_push;
    bit want;
    int g;
    pop      = (m_q.size() != 0) && (cmd_ready == 1'b1);
    can_push = (m_q.size() < DEPTH) || pop;
    g = -1;
    if (can_push)
      for (int i = N - 1; i >= 0; i--)
        if (m_pend[i]) g = i;
    for (int i = 0; i < N; i++) begin
      if (m_pulse[i] && m_pend[i] && i != g) m_ovf = 1'b1;
      m_pend[i] = (m_pend[i] && i != g) || m_pulse[i];
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) m_q.push_back(g);
    // Debounce: armed buttons look for D consecutive lows, disarmed ones for
    // D consecutive highs; the sample in the pulse cycle is not looked at.
    for (int i = 0; i < N; i++) begin
      if (m_pulse[i]) begin
        m_pulse[i] = 1'b0;
      end else begin
        want = m_armed[i] ? 1'b0 : 1'b1;
        if (m_s[i] == want) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == D) begin
          m_run[i]   = 0;
          m_pulse[i] = m_armed[i];
          m_armed[i] = !m_armed[i];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      m_s[i]     = m_sync1[i];
      m_sync1[i] = btn_n[i];
    end
  endtask

  task automatic model_compare();
    bit any_pend;
    any_pend = 1'b0;
    for (int i = 0; i < N; i++) any_pend |= m_pend[i];
    check("model_valid", 32'(cmd_valid), 32'(m_q.size() != 0));
    check("model_count", 32'(pending_count), 32'(m_q.size()));
    check("model_overflow", 32'(overflow), 32'(m_ovf));
    check("model_busy", 32'(busy), 32'(any_pend || (m_q.size() != 0)));
    if (m_q.size() != 0) check("model_id", 32'(cmd_id), 32'(m_q[0]));
  endtask

  // One clock edge: model follows the DUT edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge Clock);
    if (Resetn) model_step();
    #1;
    model_compare();
  endtask

  task automatic hold(input logic [3:0] b, input logic r, input int n);
    btn_n     = b;
    cmd_ready = r;
    repeat (n) tick();
  endtask

  task automatic press(input int i);
    hold(~(4'b0001 << i), 1'b0, 8);
    hold(4'hF, 1'b0, 8);
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_count", 32'(pending_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id", 32'(cmd_id), 32'd0);
    repeat (2) tick();
    Resetn = 1'b1;
  endtask

  int got[$];
  task automatic drain();
    got.delete();
    cmd_ready = 1'b1;
    repeat (12) begin
      if (cmd_valid) got.push_back(int'(cmd_id));
      tick();
    end
    cmd_ready = 1'b0;
  endtask

  task automatic check_drain(input string name, input int exp[$]);
    check({name, "_n"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  int seen;
  task automatic hold_c(input logic [3:0] b, input int n);
    btn_n     = b;
    cmd_ready = 1'b1;
    repeat (n) begin
      tick();
      if (cmd_valid) begin
        seen++;
        check("bounce_id", 32'(cmd_id), 32'd0);
      end
    end
  endtask

  // ---------------- directed vectors
  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    int         ticks;
    logic       v;
    logic [1:0] id;
    int         cnt;
    logic       ovf;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int exp_ids[$];
    logic [3:0] cur;
    int mode;

    // clean press of button 2, ready high
    vecs.push_back('{4'b1011, 1'b1, 6,  1'b0, 2'd0, 0, 1'b0, 1'b0});
    vecs.push_back('{4'b1011, 1'b1, 1,  1'b0, 2'd0, 0, 1'b0, 1'b1});
    vecs.push_back('{4'b1011, 1'b1, 1,  1'b1, 2'd2, 1, 1'b0, 1'b1});
    vecs.push_back('{4'b1011, 1'b1, 1,  1'b0, 2'd0, 0, 1'b0, 1'b0});
    vecs.push_back('{4'b1011, 1'b1, 12, 1'b0, 2'd0, 0, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 10, 1'b0, 2'd0, 0, 1'b0, 1'b0});
    // buttons 3, 1, 0 together, ready low, then drained in priority order
    vecs.push_back('{4'b0100, 1'b0, 6,  1'b0, 2'd0, 0, 1'b0, 1'b0});
    vecs.push_back('{4'b0100, 1'b0, 1,  1'b0, 2'd0, 0, 1'b0, 1'b1});
    vecs.push_back('{4'b0100, 1'b0, 1,  1'b1, 2'd0, 1, 1'b0, 1'b1});
    vecs.push_back('{4'b0100, 1'b0, 1,  1'b1, 2'd0, 2, 1'b0, 1'b1});
    vecs.push_back('{4'b0100, 1'b0, 1,  1'b1, 2'd0, 3, 1'b0, 1'b1});
    vecs.push_back('{4'b0100, 1'b1, 1,  1'b1, 2'd1, 2, 1'b0, 1'b1});
    vecs.push_back('{4'b0100, 1'b1, 1,  1'b1, 2'd3, 1, 1'b0, 1'b1});
    vecs.push_back('{4'b0100, 1'b1, 1,  1'b0, 2'd0, 0, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 10, 1'b0, 2'd0, 0, 1'b0, 1'b0});

    Resetn    = 1'b0;
    btn_n     = 4'hF;
    cmd_ready = 1'b0;
    model_reset();
    do_reset();

    for (int k = 0; k < vecs.size(); k++) begin
      hold(vecs[k].btn, vecs[k].rdy, vecs[k].ticks);
      check($sformatf("vec%0d_valid", k), 32'(cmd_valid), 32'(vecs[k].v));
      check($sformatf("vec%0d_count", k), 32'(pending_count), 32'(vecs[k].cnt));
      check($sformatf("vec%0d_overflow", k), 32'(overflow), 32'(vecs[k].ovf));
      check($sformatf("vec%0d_busy", k), 32'(busy), 32'(vecs[k].bsy));
      if (vecs[k].v) check($sformatf("vec%0d_id", k), 32'(cmd_id), 32'(vecs[k].id));
    end

    // bounce on button 0
    seen = 0;
    hold_c(4'b1110, 3); hold_c(4'hF, 1); hold_c(4'b1110, 3); hold_c(4'hF, 2);
    hold_c(4'hF, 6);
    check("bounce_none", 32'(seen), 32'd0);
    hold_c(4'b1110, 10); hold_c(4'b1110, 4);
    check("bounce_one", 32'(seen), 32'd1);
    hold_c(4'hF, 2); hold_c(4'b1110, 10);
    check("glitch_none", 32'(seen), 32'd1);
    hold_c(4'hF, 10);

    // full FIFO, held pending, then overflow
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    check("full_count", 32'(pending_count), 32'd4);
    press(0);
    check("held_count", 32'(pending_count), 32'd4);
    check("held_busy", 32'(busy), 32'd1);
    check("held_overflow", 32'(overflow), 32'd0);
    hold(4'b1110, 1'b0, 8);
    check("ovf_set", 32'(overflow), 32'd1);
    hold(4'hF, 1'b0, 8);
    drain();
    exp_ids = '{0, 1, 2, 3, 0};
    check_drain("ovf_drain", exp_ids);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // simultaneous push and pop at full
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    press(1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("pp_count", 32'(pending_count), 32'd4);
    check("pp_head", 32'(cmd_id), 32'd1);
    check("pp_busy", 32'(busy), 32'd1);
    drain();
    exp_ids = '{1, 2, 3, 1};
    check_drain("pp_drain", exp_ids);

    // reset in the middle of a debounce, button held through reset
    do_reset();
    press(0);
    press(1);
    check("mid_count", 32'(pending_count), 32'd2);
    hold(4'b1011, 1'b0, 4);
    do_reset();
    hold(4'b1011, 1'b0, 7);
    check("rel_valid_early", 32'(cmd_valid), 32'd0);
    tick();
    check("rel_valid", 32'(cmd_valid), 32'd1);
    check("rel_id", 32'(cmd_id), 32'd2);
    check("rel_count", 32'(pending_count), 32'd1);
    hold(4'hF, 1'b1, 10);

    // randomized traffic against the model
    cur  = 4'hF;
    mode = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) mode = int'($urandom_range(0, 2));
      if (c == 1500) do_reset();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
      btn_n = cur;
      case (mode)
        0:       cmd_ready = 1'b0;
        1:       cmd_ready = 1'($urandom_range(0, 1));
        default: cmd_ready = 1'b1;
      endcase
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
